// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus per-channel stability counter debouncer.
// Define BTN_DEBOUNCE_EDGE_EN to build the registered press/release strobes.
module btn_debounce #(
  parameter int NBTN            = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_db,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [NBTN-1:0] sync1_q, sync2_q, db_q, db_d, acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
    end
  for (genvar g = 0; g < NBTN; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             diff;
    // A bounce back to the accepted level restarts the count; acceptance also clears it.
    always_comb begin
      diff    = sync2_q[g] != db_q[g];
      acc[g]  = diff && (cnt_q == LAST);
      cnt_d   = (!diff || acc[g]) ? '0 : cnt_q + CNT_W'(1);
      db_d[g] = acc[g] ? sync2_q[g] : db_q[g];
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
  end
  assign btn_db = db_q;
`ifdef BTN_DEBOUNCE_EDGE_EN
  logic [NBTN-1:0] press_q, release_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= acc & sync2_q;
      release_q <= acc & ~sync2_q;
    end
  assign btn_press   = press_q;
  assign btn_release = release_q;
`else
  assign btn_press   = '0;
  assign btn_release = '0;
`endif
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed checks of btn_debounce with DEBOUNCE_CYCLES=4, NBTN=2.
module tb_btn_debounce;
  localparam int N = 2;
`ifdef BTN_DEBOUNCE_EDGE_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_db, btn_press, btn_release;
  int           checks = 0;
  int           errors = 0;

  btn_debounce #(.NBTN(N), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_db(btn_db), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply a clean raw level; db must change after exactly the 6th edge with one strobe.
  task automatic run(input string tag, input logic [N-1:0] raw, input logic [N-1:0] old_db,
                     input logic [N-1:0] new_db);
    logic [N-1:0] rise, fall;
    rise = new_db & ~old_db & {N{EDGE}};
    fall = old_db & ~new_db & {N{EDGE}};
    btn_raw = raw;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk({tag, "_db"}, btn_db, (k >= 5) ? new_db : old_db);
      chk({tag, "_pr"}, btn_press, (k == 5) ? rise : '0);
      chk({tag, "_rl"}, btn_release, (k == 5) ? fall : '0);
    end
  endtask

  initial begin
    logic [7:0] pat;
    int         pc;
    repeat (3) tick();
    chk("rst_db", btn_db, 2'b00);
    chk("rst_pr", btn_press, 2'b00);
    chk("rst_rl", btn_release, 2'b00);
    rst_n = 1'b1;
    tick();
    run("press", 2'b01, 2'b00, 2'b01);
    run("release", 2'b00, 2'b01, 2'b00);
    pat = 8'b1111_0111;
    pc  = 0;
    for (int k = 0; k < 12; k++) begin
      btn_raw = {1'b0, (k < 8) ? pat[k] : 1'b1};
      tick();
      chk("bounce_db", btn_db, {1'b0, k >= 9});
      pc += int'(btn_press[0]);
    end
    chk("bounce_np", N'(pc), {1'b0, EDGE});
    run("release2", 2'b00, 2'b01, 2'b00);
    for (int k = 0; k < 10; k++) begin
      btn_raw = (k < 3) ? 2'b01 : 2'b00;
      tick();
      chk("glitch_db", btn_db, 2'b00);
      chk("glitch_pr", btn_press, 2'b00);
    end
    run("press1", 2'b10, 2'b00, 2'b10);
    btn_raw = 2'b11;
    repeat (4) tick();
    chk("mid_db", btn_db, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_db", btn_db, 2'b00);
    chk("arst_pr", btn_press, 2'b00);
    chk("arst_rl", btn_release, 2'b00);
    repeat (3) tick();
    chk("inrst_db", btn_db, 2'b00);
    rst_n = 1'b1;
    run("held", 2'b11, 2'b00, 2'b11);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/btn_debounce.md
# btn_debounce

Input conditioning stage placed directly upstream of the button-to-LED logic. It synchronizes NBTN raw mechanical push-button inputs into the system clock domain and debounces them. It drives clean, glitch-free levels (`btn_db`) that feed the downstream `btn0`/`btn1` inputs. Optional single-cycle press/release strobes are provided for event-driven consumers.

## Interface
Parameters:
- `NBTN`, default 2: number of independent button channels.
- `DEBOUNCE_CYCLES`, default 50000: consecutive clock cycles a new level must persist before acceptance (1 ms at 50 MHz). Legal range 2 ≤ DEBOUNCE_CYCLES < 2**CNT_W.
- `CNT_W`, default 16: width of each per-channel stability counter.

Ports:
- `clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset; release is synchronized externally.
- `btn_raw` input NBTN: raw, asynchronous, bouncing button levels (1 = pressed).
- `btn_db` output NBTN: debounced level per channel; reset 0.
- `btn_press` output NBTN: one-cycle strobe on a debounced 0→1 transition; reset 0.
- `btn_release` output NBTN: one-cycle strobe on a debounced 1→0 transition; reset 0.

## Operation
- Each channel is fully independent. There is no shared state between channels.
- Synchronizer: two-flop chain `sync1 <= btn_raw[i]`, `sync2 <= sync1`. Both flops reset to 0. Only `sync2` is used downstream.
- Stability counter `cnt[i]` (CNT_W bits, reset 0):
  - `sync2 == btn_db[i]`: `cnt <= 0`. Any bounce back to the accepted level restarts the count.
  - `sync2 != btn_db[i]` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - `sync2 != btn_db[i]` and `cnt == DEBOUNCE_CYCLES-1`: `btn_db[i] <= sync2`, `cnt <= 0`.
- The counter never wraps. Its maximum value is DEBOUNCE_CYCLES-1.
- Strobes are registered and asserted in the same cycle in which `btn_db` first shows the new value:
  - `btn_press[i]` is high for exactly one cycle on an accepted rise.
  - `btn_release[i]` is high for exactly one cycle on an accepted fall.
  - Otherwise both strobes are 0.
- The state per channel is implicit: STABLE (cnt == 0, sync2 == db) or PENDING (mismatch, counting). Transitions:
  - PENDING→STABLE on acceptance.
  - PENDING→STABLE on a bounce back to the accepted level, with no output change.
- Asynchronous reset mid-count clears sync flops, counters, `btn_db` and the strobes immediately. No strobe is emitted on reset.
- If a button is held through reset release, it is treated as a new 0→1 change. `btn_db` rises and `btn_press` pulses after the full latency.

## Timing
- Latency: a clean raw change set up before rising edge E0 appears on `btn_db` after edge E0+DEBOUNCE_CYCLES+1. That is DEBOUNCE_CYCLES+2 edges, of which 2 are synchronizer and DEBOUNCE_CYCLES are counting.
- Minimum accepted pulse width: DEBOUNCE_CYCLES cycles at `sync2`. Anything shorter produces no output change and no strobe.
- Strobe width: exactly 1 cycle. Back-to-back accepted transitions on one channel are separated by at least DEBOUNCE_CYCLES cycles.
- Simultaneous changes on several channels are each accepted in their own cycle. Strobes may coincide across channels.
- Outputs are fully registered, with no combinational path from `btn_raw`.

## Configuration
- `BTN_DEBOUNCE_EDGE_EN` defined: the press/release strobe registers and logic are compiled in, as described above.
- `BTN_DEBOUNCE_EDGE_EN` undefined: `btn_press` and `btn_release` are tied to constant 0 and no strobe flops exist. Synchronizer, counters and `btn_db` behaviour are unchanged.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and NBTN=2 unless stated.
- Clean press: `btn_raw[0]` 0→1 before edge E0 → `btn_db[0]` = 1 after E5. `btn_press[0]` = 1 only in that cycle. `btn_db[1]` stays 0.
- Bounce rejection: raw pattern 1,1,1,0,1,1,1,1 (one cycle each) → `btn_db[0]` rises only after 4 consecutive 1s at `sync2`. Exactly one `btn_press[0]` pulse.
- Glitch rejection: a 3-cycle raw high pulse → `btn_db` stays 0 and no strobe.
- Release: after an accepted press, raw 1→0 → `btn_db[0]` falls after E0+5. `btn_release[0]` is a single 1-cycle pulse.
- Reset mid-count and held button: assert `rst_n`=0 with cnt = 2 → all outputs 0 immediately. Then release reset with raw held at 1 → `btn_db` rises 6 edges after the first post-reset edge, with a `btn_press` pulse.
- Macro off, both channels pressed simultaneously → both `btn_db` rise in the same cycle and `btn_press` = `btn_release` = 0 throughout.
